// File: rtl/psum_pkg.sv
// Shared encodings for the psum buffer arbiter: read-return tags and clear FSM states.
package psum_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_ACC  = 2'd1,
    TAG_DRN  = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  localparam int MEM_DELAY_DEFAULT = 1;

endpackage

// File: rtl/psum_rd_tag_pipe.sv
// Tracks who issued each buffer read and steers the matching return to that requester.
module psum_rd_tag_pipe
  import psum_pkg::*;
#(
  parameter int MEM_DELAY = MEM_DELAY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  tag_e issue_tag,
  input  logic mem_ovld,
  output logic acc_ovld,
  output logic drn_ovld,
  output logic err
);

  tag_e pipe [MEM_DELAY];
  tag_e ret_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DELAY; i++) pipe[i] <= TAG_NONE;
      err <= 1'b0;
    end else begin
      pipe[0] <= issue_tag;
      for (int i = 1; i < MEM_DELAY; i++) pipe[i] <= pipe[i-1];
      // A return with no outstanding read means the buffer and our pipe disagree.
      if (mem_ovld && (ret_tag == TAG_NONE)) err <= 1'b1;
    end
  end

  assign ret_tag  = pipe[MEM_DELAY-1];
  assign acc_ovld = mem_ovld && (ret_tag == TAG_ACC);
  assign drn_ovld = mem_ovld && (ret_tag == TAG_DRN);

endmodule

// File: rtl/psum_mem_arbiter.sv
// Shares one dual-port psum buffer between the accumulator, the result drain and a zero-fill engine.
//   state    | meaning
//   CLR_IDLE | waiting for a clear request while the accumulator is quiet
//   CLR_RUN  | writing zeros from address 0, yielding to accumulator writes
//   CLR_DONE | one-cycle tail before returning to idle
module psum_mem_arbiter
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_DELAY  = MEM_DELAY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] acc_radd,
  input  logic                  acc_rden,
  input  logic [ADDR_WIDTH-1:0] acc_wadd,
  input  logic                  acc_wren,
  input  logic [DATA_WIDTH-1:0] acc_idat,
  output logic [DATA_WIDTH-1:0] acc_odat,
  output logic                  acc_ovld,
  input  logic [ADDR_WIDTH-1:0] drn_radd,
  input  logic                  drn_rden,
  output logic                  drn_rrdy,
  output logic [DATA_WIDTH-1:0] drn_odat,
  output logic                  drn_ovld,
  input  logic                  i_clr_start,
  input  logic [REG_WIDTH-1:0]  i_clr_len,
  output logic                  o_clr_busy,
  output logic                  o_acc_busy,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_ovld,
  output logic                  o_err,
  output logic [REG_WIDTH-1:0]  dbg_drn_stall_cnt
);

  localparam int BUSY_W = $clog2(MEM_DELAY + 3);

  tag_e                  issue_tag;
  clr_state_e            clr_state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [REG_WIDTH-1:0]  clr_len;
  logic [BUSY_W-1:0]     busy_cnt;

  // Read port: the accumulator cannot stall, so the drain only goes when it is absent.
  always_comb begin
    drn_rrdy  = 1'b0;
    mem_rden  = 1'b0;
    mem_radd  = drn_radd;
    issue_tag = TAG_NONE;
    if (acc_rden) begin
      mem_rden  = 1'b1;
      mem_radd  = acc_radd;
      issue_tag = TAG_ACC;
    end else begin
      drn_rrdy = ~o_acc_busy | ~acc_rden;
      if (drn_rden) begin
        mem_rden  = 1'b1;
        issue_tag = TAG_DRN;
      end
    end
  end

  always_comb begin
    mem_wren = 1'b0;
    mem_wadd = clr_addr;
    mem_idat = '0;
    if (acc_wren) begin
      mem_wren = 1'b1;
      mem_wadd = acc_wadd;
      mem_idat = acc_idat;
    end else if (clr_state == CLR_RUN) begin
      mem_wren = 1'b1;
    end
  end

  psum_rd_tag_pipe #(
    .MEM_DELAY (MEM_DELAY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue_tag (issue_tag),
    .mem_ovld  (mem_ovld),
    .acc_ovld  (acc_ovld),
    .drn_ovld  (drn_ovld),
    .err       (o_err)
  );

  assign acc_odat = mem_odat;
  assign drn_odat = mem_odat;

  // Activity window covers the accumulator's read-modify-write latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (acc_rden || acc_wren) begin
      busy_cnt <= BUSY_W'(MEM_DELAY + 2);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - BUSY_W'(1);
    end
  end

  assign o_acc_busy = (busy_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_drn_stall_cnt <= '0;
    end else if (drn_rden && !drn_rrdy) begin
      dbg_drn_stall_cnt <= dbg_drn_stall_cnt + REG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state  <= CLR_IDLE;
      clr_addr   <= '0;
      clr_len    <= '0;
      o_clr_busy <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (i_clr_start && (i_clr_len != '0) && !o_acc_busy) begin
            clr_state  <= CLR_RUN;
            clr_addr   <= '0;
            clr_len    <= i_clr_len;
            o_clr_busy <= 1'b1;
          end
        end
        CLR_RUN: begin
          // A cycle taken by an accumulator write leaves clr_addr untouched for a retry.
          if (!acc_wren) begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
            if (clr_addr == ADDR_WIDTH'(clr_len - REG_WIDTH'(1))) clr_state <= CLR_DONE;
          end
        end
        CLR_DONE: begin
          clr_state  <= CLR_IDLE;
          o_clr_busy <= 1'b0;
        end
        default: begin
          clr_state  <= CLR_IDLE;
          o_clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed bench for psum_mem_arbiter with a one-cycle-latency buffer model.
module tb_psum_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] acc_radd, acc_wadd, acc_idat, drn_radd, i_clr_len;
  logic        acc_rden, acc_wren, drn_rden, i_clr_start;
  logic [31:0] acc_odat, drn_odat, mem_radd, mem_wadd, mem_idat, dbg_drn_stall_cnt;
  logic        acc_ovld, drn_rrdy, drn_ovld, o_clr_busy, o_acc_busy;
  logic        mem_rden, mem_wren, o_err;
  logic [31:0] mem_odat;
  logic        mem_ovld, ovld_r, inj_ovld;
  logic [31:0] mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_addr [16];
  logic [31:0] wr_dat  [16];
  int          wr_n, busy_n;
  int          exp5 [9];

  typedef struct packed {
    logic        acc_rden;
    logic [31:0] acc_radd;
    logic        drn_rden;
    logic [31:0] drn_radd;
    logic        acc_wren;
    logic [31:0] acc_wadd;
    logic [31:0] acc_idat;
    logic        e_rden;
    logic [31:0] e_radd;
    logic        e_rrdy;
    logic        e_wren;
    logic [31:0] e_wadd;
    logic [31:0] e_idat;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  psum_mem_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .acc_radd          (acc_radd),
    .acc_rden          (acc_rden),
    .acc_wadd          (acc_wadd),
    .acc_wren          (acc_wren),
    .acc_idat          (acc_idat),
    .acc_odat          (acc_odat),
    .acc_ovld          (acc_ovld),
    .drn_radd          (drn_radd),
    .drn_rden          (drn_rden),
    .drn_rrdy          (drn_rrdy),
    .drn_odat          (drn_odat),
    .drn_ovld          (drn_ovld),
    .i_clr_start       (i_clr_start),
    .i_clr_len         (i_clr_len),
    .o_clr_busy        (o_clr_busy),
    .o_acc_busy        (o_acc_busy),
    .mem_radd          (mem_radd),
    .mem_rden          (mem_rden),
    .mem_wadd          (mem_wadd),
    .mem_wren          (mem_wren),
    .mem_idat          (mem_idat),
    .mem_odat          (mem_odat),
    .mem_ovld          (mem_ovld),
    .o_err             (o_err),
    .dbg_drn_stall_cnt (dbg_drn_stall_cnt)
  );

  // Buffer model: word i preloads to A000_0000+i, reads return one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_wren) begin
      mem[mem_wadd[5:0]] <= mem_idat;
    end
    ovld_r   <= mem_rden;
    mem_odat <= mem[mem_radd[5:0]];
  end

  assign mem_ovld = ovld_r | inj_ovld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    acc_rden = 0; acc_radd = 0; acc_wren = 0; acc_wadd = 0; acc_idat = 0;
    drn_rden = 0; drn_radd = 0; i_clr_start = 0; i_clr_len = 0; inj_ovld = 0;
  endtask

  task automatic wait_acc_idle();
    for (int i = 0; i < 10 && o_acc_busy; i++) step();
    check("acc_idle_wait", {31'b0, o_acc_busy}, 32'd0);
  endtask

  task automatic run_clear(input logic [31:0] len, input int blk);
    wr_n = 0;
    busy_n = 0;
    i_clr_start = 1; i_clr_len = len;
    step();
    i_clr_start = 0; i_clr_len = 0;
    for (int c = 0; c < 20; c++) begin
      acc_wren = (c == blk); acc_wadd = 32'd40; acc_idat = 32'h55;
      #1;
      if (o_clr_busy) busy_n++;
      if (mem_wren && wr_n < 16) begin
        wr_addr[wr_n] = mem_wadd;
        wr_dat[wr_n]  = mem_idat;
        wr_n++;
      end
      step();
    end
    acc_wren = 0;
  endtask

  task automatic drain_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    drn_rden = 1; drn_radd = addr;
    step();
    drn_rden = 0;
    #1;
    check({name, "_vld"}, {31'b0, drn_ovld}, 32'd1);
    check({name, "_dat"}, drn_odat, exp);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             acc_rden radd      drn_rden radd      acc_wren wadd     idat           e_rden e_radd     e_rrdy e_wren e_wadd   e_idat
    vecs[0] = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0};
    vecs[1] = '{1'b1, 32'h12, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        1'b1, 32'h12, 1'b0, 1'b0, 32'h00, 32'h0};
    vecs[2] = '{1'b0, 32'h00, 1'b1, 32'h21, 1'b0, 32'h00, 32'h0,        1'b1, 32'h21, 1'b1, 1'b0, 32'h00, 32'h0};
    vecs[3] = '{1'b1, 32'h33, 1'b1, 32'h22, 1'b0, 32'h00, 32'h0,        1'b1, 32'h33, 1'b0, 1'b0, 32'h00, 32'h0};
    vecs[4] = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h30, 32'hDEAD,     1'b0, 32'h00, 1'b1, 1'b1, 32'h30, 32'hDEAD};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 32'h23, 1'b1, 32'h31, 32'hBEEF,     1'b1, 32'h23, 1'b1, 1'b1, 32'h31, 32'hBEEF};
    vecs[6] = '{1'b1, 32'h3F, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        1'b1, 32'h3F, 1'b0, 1'b0, 32'h00, 32'h0};
    exp5 = '{0, 1, 2, 40, 3, 4, 5, 6, 7};

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    #1;
    check("rst_clr_busy", {31'b0, o_clr_busy}, 32'd0);
    check("rst_acc_busy", {31'b0, o_acc_busy}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check("rst_stall", dbg_drn_stall_cnt, 32'd0);
    check("rst_acc_ovld", {31'b0, acc_ovld}, 32'd0);
    check("rst_drn_ovld", {31'b0, drn_ovld}, 32'd0);
    check("rst_mem_wren", {31'b0, mem_wren}, 32'd0);
    check("rst_mem_rden", {31'b0, mem_rden}, 32'd0);
    step();

    // Combinational read and write muxes; vecs[3] is one drain stall.
    for (int i = 0; i < 7; i++) begin
      acc_rden = vecs[i].acc_rden; acc_radd = vecs[i].acc_radd;
      drn_rden = vecs[i].drn_rden; drn_radd = vecs[i].drn_radd;
      acc_wren = vecs[i].acc_wren; acc_wadd = vecs[i].acc_wadd; acc_idat = vecs[i].acc_idat;
      #1;
      check($sformatf("vec%0d_rden", i), {31'b0, mem_rden}, {31'b0, vecs[i].e_rden});
      if (vecs[i].e_rden) check($sformatf("vec%0d_radd", i), mem_radd, vecs[i].e_radd);
      check($sformatf("vec%0d_rrdy", i), {31'b0, drn_rrdy}, {31'b0, vecs[i].e_rrdy});
      check($sformatf("vec%0d_wren", i), {31'b0, mem_wren}, {31'b0, vecs[i].e_wren});
      if (vecs[i].e_wren) begin
        check($sformatf("vec%0d_wadd", i), mem_wadd, vecs[i].e_wadd);
        check($sformatf("vec%0d_idat", i), mem_idat, vecs[i].e_idat);
      end
      step();
    end
    idle_inputs();
    step(); step();

    // Drain back-to-back, data one cycle behind.
    for (int k = 0; k < 5; k++) begin
      drn_rden = (k < 4); drn_radd = 32'(k);
      #1;
      if (k < 4) begin
        check($sformatf("b2b_rrdy%0d", k), {31'b0, drn_rrdy}, 32'd1);
        check($sformatf("b2b_radd%0d", k), mem_radd, 32'(k));
      end
      if (k > 0) begin
        check($sformatf("b2b_vld%0d", k - 1), {31'b0, drn_ovld}, 32'd1);
        check($sformatf("b2b_dat%0d", k - 1), drn_odat, 32'hA000_0000 + 32'(k - 1));
        check($sformatf("b2b_accvld%0d", k - 1), {31'b0, acc_ovld}, 32'd0);
      end
      step();
    end
    idle_inputs();
    step();

    // Accumulator and drain collide.
    acc_rden = 1; acc_radd = 32'd10; drn_rden = 1; drn_radd = 32'd5;
    #1;
    check("col_rrdy", {31'b0, drn_rrdy}, 32'd0);
    check("col_radd", mem_radd, 32'd10);
    step();
    acc_rden = 0;
    #1;
    check("col_rrdy2", {31'b0, drn_rrdy}, 32'd1);
    check("col_radd2", mem_radd, 32'd5);
    check("col_acc_vld", {31'b0, acc_ovld}, 32'd1);
    check("col_acc_dat", acc_odat, 32'hA000_000A);
    check("col_drn_vld0", {31'b0, drn_ovld}, 32'd0);
    check("col_acc_busy", {31'b0, o_acc_busy}, 32'd1);
    step();
    drn_rden = 0;
    #1;
    check("col_drn_vld", {31'b0, drn_ovld}, 32'd1);
    check("col_drn_dat", drn_odat, 32'hA000_0005);
    check("col_stall", dbg_drn_stall_cnt, 32'd2);
    step();

    // Drain read followed by accumulator read.
    drn_rden = 1; drn_radd = 32'd2;
    step();
    drn_rden = 0; acc_rden = 1; acc_radd = 32'd7;
    #1;
    check("ord_drn_vld", {31'b0, drn_ovld}, 32'd1);
    check("ord_drn_dat", drn_odat, 32'hA000_0002);
    check("ord_acc_vld0", {31'b0, acc_ovld}, 32'd0);
    step();
    acc_rden = 0;
    #1;
    check("ord_acc_vld", {31'b0, acc_ovld}, 32'd1);
    check("ord_acc_dat", acc_odat, 32'hA000_0007);
    check("ord_drn_vld1", {31'b0, drn_ovld}, 32'd0);
    check("ord_err", {31'b0, o_err}, 32'd0);
    step();

    // Unblocked clear of 8 words.
    wait_acc_idle();
    run_clear(32'd8, -1);
    check("clr8_writes", 32'(wr_n), 32'd8);
    check("clr8_busy_cycles", 32'(busy_n), 32'd9);
    for (int i = 0; i < 8 && i < wr_n; i++) begin
      check($sformatf("clr8_addr%0d", i), wr_addr[i], 32'(i));
      check($sformatf("clr8_dat%0d", i), wr_dat[i], 32'd0);
    end
    drain_read(32'd3, 32'd0, "clr8_rb3");
    drain_read(32'd7, 32'd0, "clr8_rb7");
    drain_read(32'd8, 32'hA000_0008, "clr8_rb8");

    // Clear with an accumulator write stealing the addr-3 slot.
    wait_acc_idle();
    run_clear(32'd8, 3);
    check("clrblk_writes", 32'(wr_n), 32'd9);
    check("clrblk_busy_cycles", 32'(busy_n), 32'd10);
    for (int i = 0; i < 9 && i < wr_n; i++) begin
      check($sformatf("clrblk_addr%0d", i), wr_addr[i], 32'(exp5[i]));
      check($sformatf("clrblk_dat%0d", i), wr_dat[i], (i == 3) ? 32'h55 : 32'd0);
    end
    drain_read(32'd40, 32'h55, "clrblk_rb40");

    // Zero length is a no-op.
    wait_acc_idle();
    i_clr_start = 1; i_clr_len = 32'd0;
    step();
    i_clr_start = 0;
    #1;
    check("len0_busy", {31'b0, o_clr_busy}, 32'd0);
    check("len0_wren", {31'b0, mem_wren}, 32'd0);
    step();

    // Spurious return sets a sticky error.
    inj_ovld = 1;
    step();
    inj_ovld = 0;
    #1;
    check("err_set", {31'b0, o_err}, 32'd1);
    step(); step(); step();
    check("err_sticky", {31'b0, o_err}, 32'd1);

    // Start while accumulator busy is dropped; busy window lasts MEM_DELAY+2 cycles.
    acc_wren = 1; acc_wadd = 32'd50; acc_idat = 32'd1;
    step();
    acc_wren = 0; i_clr_start = 1; i_clr_len = 32'd4;
    #1;
    check("busy_at_start", {31'b0, o_acc_busy}, 32'd1);
    step();
    i_clr_start = 0; i_clr_len = 0;
    #1;
    check("busy_start_ignored", {31'b0, o_clr_busy}, 32'd0);
    step();
    check("busy_tail_on", {31'b0, o_acc_busy}, 32'd1);
    check("busy_start_nowr", {31'b0, mem_wren}, 32'd0);
    step();
    check("busy_tail_off", {31'b0, o_acc_busy}, 32'd0);
    check("busy_start_idle", {31'b0, o_clr_busy}, 32'd0);

    // Reset in the middle of a clear.
    i_clr_start = 1; i_clr_len = 32'd8;
    step();
    i_clr_start = 0; i_clr_len = 0;
    step();
    check("midclr_busy", {31'b0, o_clr_busy}, 32'd1);
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    check("rst2_clr_busy", {31'b0, o_clr_busy}, 32'd0);
    check("rst2_err", {31'b0, o_err}, 32'd0);
    check("rst2_stall", dbg_drn_stall_cnt, 32'd0);
    check("rst2_wren", {31'b0, mem_wren}, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
